// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Build option: RF_ARB_FIXED_PRIO_EN selects fixed lowest-index priority
// instead of round-robin arbitration.
package rf_arb_pkg;

  localparam int REG_COUNT = 32;
  localparam int ZERO_REG  = 0;
  localparam int CLR_FIRST = 1;
  localparam int CLR_LAST  = 31;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Increment with wrap at n (n > 0); used for the round-robin pointer.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Single-grant arbiter over NUM_REQ requesters.
// Default: round-robin search starting at rr_ptr, wrapping at NUM_REQ-1.
// With RF_ARB_FIXED_PRIO_EN defined: lowest set index wins, no pointer port.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
`ifndef RF_ARB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0]   rr_ptr,
`endif
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic found;
  int   cand;

  // Scan candidates in priority order; first requesting one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef RF_ARB_FIXED_PRIO_EN
      cand = k;
`else
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
`endif
      if (enable && !found && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port among NUM_REQ writeback
// requesters, sequences a hardware clear of $1..$31, and exposes forwarding
// hits for the one-cycle window between grant and commit.
// Build option: RF_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
module regfile_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        clear_req,
  output logic                        clear_done,
  output logic                        busy,
  output logic [ADDR_W-1:0]           rf_address_W,
  output logic [DATA_W-1:0]           rf_write_data,
  output logic                        rf_write_enable,
  input  logic [ADDR_W-1:0]           fwd_addr_A,
  input  logic [ADDR_W-1:0]           fwd_addr_B,
  output logic                        fwd_hit_A,
  output logic                        fwd_hit_B,
  output logic [DATA_W-1:0]           fwd_data
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Per-requester views of the flattened request buses.
  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_v;
  logic [NUM_REQ-1:0][DATA_W-1:0] data_v;
  assign addr_v = req_addr;
  assign data_v = req_data;

  state_t             state;
  logic [ADDR_W-1:0]  clr_idx;
  logic               arb_en;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_vld;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  // Grants only in ARB, never while a clear is being requested, never in reset.
  assign arb_en    = rst_n && (state == ARB) && !clear_req;
  assign grant_vld = |grant;
  assign req_ready = grant;
  assign sel_addr  = addr_v[grant_idx];
  assign sel_data  = data_v[grant_idx];
  assign busy      = (state == CLEAR);

`ifndef RF_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] rr_ptr;

  // Round-robin pointer moves just past the last winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_vld) begin
      rr_ptr <= IDX_W'(wrap_inc(32'(grant_idx), NUM_REQ));
    end
  end
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req       (req_valid),
`ifndef RF_ARB_FIXED_PRIO_EN
    .rr_ptr    (rr_ptr),
`endif
    .enable    (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // FSM, clear counter and the registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ARB;
      clr_idx         <= ADDR_W'(CLR_FIRST);
      rf_write_enable <= 1'b0;
      rf_address_W    <= '0;
      rf_write_data   <= '0;
      clear_done      <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        ARB: begin
          if (clear_req) begin
            // The pending write (if any) commits this cycle; nothing new follows.
            rf_write_enable <= 1'b0;
            state           <= CLEAR;
          end else if (grant_vld) begin
            rf_address_W    <= sel_addr;
            rf_write_data   <= sel_data;
            // $0 writes are consumed but never reach the register file.
            rf_write_enable <= (sel_addr != ADDR_W'(ZERO_REG));
          end else begin
            rf_write_enable <= 1'b0;
          end
        end
        CLEAR: begin
          rf_write_enable <= 1'b1;
          rf_address_W    <= clr_idx;
          rf_write_data   <= '0;
          if (clr_idx == ADDR_W'(CLR_LAST)) begin
            clr_idx    <= ADDR_W'(CLR_FIRST);
            clear_done <= 1'b1;
            state      <= ARB;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  // Forwarding: the registered write is visible before it commits.
  assign fwd_hit_A = rf_write_enable && (rf_address_W == fwd_addr_A) &&
                     (fwd_addr_A != ADDR_W'(ZERO_REG));
  assign fwd_hit_B = rf_write_enable && (rf_address_W == fwd_addr_B) &&
                     (fwd_addr_B != ADDR_W'(ZERO_REG));
  assign fwd_data  = rf_write_data;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed vector table,
// hand-written clear / reset sequences, then random traffic against a
// transaction-level model with a final register-file content comparison.
module tb_regfile_write_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        v;
  logic [ADDR_W-1:0]         a [NUM_REQ];
  logic [DATA_W-1:0]         d [NUM_REQ];
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      clear_req, clear_done, busy;
  logic [ADDR_W-1:0]         rf_address_W;
  logic [DATA_W-1:0]         rf_write_data;
  logic                      rf_write_enable;
  logic [ADDR_W-1:0]         fa, fb;
  logic                      fwd_hit_A, fwd_hit_B;
  logic [DATA_W-1:0]         fwd_data;

  always #5 clk = ~clk;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_pack
    assign req_addr[i*ADDR_W +: ADDR_W] = a[i];
    assign req_data[i*DATA_W +: DATA_W] = d[i];
  end

  regfile_write_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(v), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .clear_req(clear_req), .clear_done(clear_done), .busy(busy),
    .rf_address_W(rf_address_W), .rf_write_data(rf_write_data),
    .rf_write_enable(rf_write_enable), .fwd_addr_A(fa), .fwd_addr_B(fb),
    .fwd_hit_A(fwd_hit_A), .fwd_hit_B(fwd_hit_B), .fwd_data(fwd_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- shadow register file fed from the DUT write port
  logic [DATA_W-1:0] srf [32];
  bit shadow_on  = 1'b0;
  bit shadow_clr = 1'b0;
  always @(posedge clk) begin
    if (shadow_clr) begin
      for (int i = 0; i < 32; i++) srf[i] <= 32'hA5A5_0000 | 32'(i);
    end else if (shadow_on && rf_write_enable) begin
      srf[rf_address_W] <= rf_write_data;
    end
  end

  // ---------------- transaction-level reference model
  int                m_ptr, m_clr, m_g, last_g;
  bit                m_clearing;
  logic              m_we, m_done;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic [DATA_W-1:0] mrf [32];

  function automatic int pick(input logic [NUM_REQ-1:0] vv, input int ptr);
    int j;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef RF_ARB_FIXED_PRIO_EN
      j = k;
`else
      j = (ptr + k) % NUM_REQ;
`endif
      if (vv[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_clearing = 0; m_clr = 1; m_we = 0; m_addr = '0; m_data = '0;
    m_done = 0; m_g = -1; last_g = -1;
  endtask

  task automatic model_comb_check();
    logic [NUM_REQ-1:0] er;
    m_g = (rst_n && !m_clearing && !clear_req) ? pick(v, m_ptr) : -1;
    er = '0;
    if (m_g >= 0) er[m_g] = 1'b1;
    chk("rnd_ready", req_ready, er);
    chk("rnd_busy", busy, m_clearing);
    chk("rnd_hitA", fwd_hit_A, m_we && (m_addr == fa) && (fa != 0));
    chk("rnd_hitB", fwd_hit_B, m_we && (m_addr == fb) && (fb != 0));
  endtask

  // Advance the model across one clock edge.
  task automatic model_step();
    if (m_clearing) begin
      m_we = 1; m_addr = ADDR_W'(m_clr); m_data = '0; mrf[m_clr] = '0;
      if (m_clr == 31) begin m_clearing = 0; m_clr = 1; m_done = 1; end
      else begin m_clr++; m_done = 0; end
    end else begin
      m_done = 0;
      if (clear_req) begin
        m_clearing = 1; m_we = 0;
      end else if (m_g >= 0) begin
        m_addr = a[m_g]; m_data = d[m_g]; m_we = (a[m_g] != 0);
        if (a[m_g] != 0) mrf[a[m_g]] = d[m_g];
        m_ptr = (m_g + 1) % NUM_REQ;
      end else begin
        m_we = 0;
      end
    end
  endtask

  task automatic model_reg_check();
    chk("rnd_we", rf_write_enable, m_we);
    chk("rnd_addr", rf_address_W, m_addr);
    chk("rnd_data", rf_write_data, m_data);
    chk("rnd_fwd_data", fwd_data, m_data);
    chk("rnd_done", clear_done, m_done);
  endtask

  // One random cycle; entered and left at posedge+1.
  task automatic rcycle(input bit allow);
    model_reg_check();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (last_g == i || !v[i]) begin
        v[i] = allow && ($urandom_range(0, 2) != 0);
        a[i] = ADDR_W'($urandom);
        d[i] = $urandom;
      end
    end
    clear_req = allow && ($urandom_range(0, 99) == 0);
    fa = ($urandom_range(0, 2) == 0) ? m_addr : ADDR_W'($urandom);
    fb = ($urandom_range(0, 2) == 0) ? m_addr : ADDR_W'($urandom);
    #1;
    model_comb_check();
    last_g = m_g;
    model_step();
    @(posedge clk); #1;
  endtask

  // ---------------- directed vector table
  typedef struct {
    logic [2:0]  v;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic [4:0]  fa, fb;
    logic [2:0]  rdy;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        ha, hb;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] vv, input logic [4:0] a0, a1, a2,
                              input logic [31:0] d0, d1, d2, input logic [4:0] xa, xb,
                              input logic [2:0] rdy, input logic we, input logic [4:0] ad,
                              input logic [31:0] dt, input logic ha, hb);
    vec_t r;
    r.v = vv; r.a0 = a0; r.a1 = a1; r.a2 = a2; r.d0 = d0; r.d1 = d1; r.d2 = d2;
    r.fa = xa; r.fb = xb; r.rdy = rdy; r.we = we; r.addr = ad; r.data = dt;
    r.ha = ha; r.hb = hb;
    return r;
  endfunction

  vec_t tbl [9];
  int   done_cnt;

  initial begin
    // rows 0..5: all three requesters held with addresses 5/6/7
`ifdef RF_ARB_FIXED_PRIO_EN
    for (int r = 0; r < 6; r++)
      tbl[r] = mk(3'b111, 5'd5, 5'd6, 5'd7, 32'h50, 32'h60, 32'h70, 5'd0, 5'd0,
                  3'b001, 1'b1, 5'd5, 32'h50, 1'b0, 1'b0);
`else
    tbl[0] = mk(3'b111, 5'd5, 5'd6, 5'd7, 32'h50, 32'h60, 32'h70, 5'd0, 5'd0, 3'b001, 1'b1, 5'd5, 32'h50, 1'b0, 1'b0);
    tbl[1] = mk(3'b111, 5'd5, 5'd6, 5'd7, 32'h50, 32'h60, 32'h70, 5'd0, 5'd0, 3'b010, 1'b1, 5'd6, 32'h60, 1'b0, 1'b0);
    tbl[2] = mk(3'b111, 5'd5, 5'd6, 5'd7, 32'h50, 32'h60, 32'h70, 5'd0, 5'd0, 3'b100, 1'b1, 5'd7, 32'h70, 1'b0, 1'b0);
    tbl[3] = mk(3'b111, 5'd5, 5'd6, 5'd7, 32'h50, 32'h60, 32'h70, 5'd0, 5'd0, 3'b001, 1'b1, 5'd5, 32'h50, 1'b0, 1'b0);
    tbl[4] = mk(3'b111, 5'd5, 5'd6, 5'd7, 32'h50, 32'h60, 32'h70, 5'd0, 5'd0, 3'b010, 1'b1, 5'd6, 32'h60, 1'b0, 1'b0);
    tbl[5] = mk(3'b111, 5'd5, 5'd6, 5'd7, 32'h50, 32'h60, 32'h70, 5'd0, 5'd0, 3'b100, 1'b1, 5'd7, 32'h70, 1'b0, 1'b0);
`endif
    // $0 write: accepted, enable dropped
    tbl[6] = mk(3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 5'd0, 5'd0, 3'b010, 1'b0, 5'd0, 32'hDEADBEEF, 1'b0, 1'b0);
    // forwarding hit on port A only
    tbl[7] = mk(3'b001, 5'd9, 5'd0, 5'd0, 32'h1234, 32'h0, 32'h0, 5'd9, 5'd0, 3'b001, 1'b1, 5'd9, 32'h1234, 1'b1, 1'b0);
    // idle: enable drops, address/data hold, no hit
    tbl[8] = mk(3'b000, 5'd9, 5'd0, 5'd0, 32'h1234, 32'h0, 32'h0, 5'd9, 5'd0, 3'b000, 1'b0, 5'd9, 32'h1234, 1'b0, 1'b0);

    // ---- reset with valids asserted
    rst_n = 1'b0; clear_req = 1'b0; fa = '0; fb = '0;
    v = 3'b111; a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd3; d[0] = 32'h1; d[1] = 32'h2; d[2] = 32'h3;
    #12;
    chk("rst_ready", req_ready, 3'b000);
    chk("rst_we", rf_write_enable, 1'b0);
    chk("rst_addr", rf_address_W, 5'd0);
    chk("rst_data", rf_write_data, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", clear_done, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1; v = '0;
    repeat (2) begin @(posedge clk); #1; chk("idle_we", rf_write_enable, 1'b0); end

    // ---- vector table
    for (int r = 0; r < 9; r++) begin
      v = tbl[r].v; a[0] = tbl[r].a0; a[1] = tbl[r].a1; a[2] = tbl[r].a2;
      d[0] = tbl[r].d0; d[1] = tbl[r].d1; d[2] = tbl[r].d2; fa = tbl[r].fa; fb = tbl[r].fb;
      #1;
      chk($sformatf("tbl%0d_ready", r), req_ready, tbl[r].rdy);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_we", r), rf_write_enable, tbl[r].we);
      chk($sformatf("tbl%0d_addr", r), rf_address_W, tbl[r].addr);
      chk($sformatf("tbl%0d_data", r), rf_write_data, tbl[r].data);
      chk($sformatf("tbl%0d_fwd_data", r), fwd_data, tbl[r].data);
      chk($sformatf("tbl%0d_hitA", r), fwd_hit_A, tbl[r].ha);
      chk($sformatf("tbl%0d_hitB", r), fwd_hit_B, tbl[r].hb);
    end

    // ---- asynchronous reset mid-cycle while the port holds addr 9 / 0x1234
    #2; rst_n = 1'b0; v = 3'b111; #1;
    chk("arst_ready", req_ready, 3'b000);
    chk("arst_addr", rf_address_W, 5'd0);
    chk("arst_data", rf_write_data, 32'd0);
    chk("arst_we", rf_write_enable, 1'b0);
    @(posedge clk); #1; rst_n = 1'b1; v = '0; fa = '0; fb = '0;

    // ---- clear while requester 2 is waiting
    v = 3'b100; a[2] = 5'd3; d[2] = 32'hAA; clear_req = 1'b1; #1;
    chk("clr_ready0", req_ready, 3'b000);
    chk("clr_busy0", busy, 1'b0);
    @(posedge clk); #1; clear_req = 1'b0;
    chk("clr_we0", rf_write_enable, 1'b0);
    done_cnt = 0;
    for (int k = 1; k <= 31; k++) begin
      #1;
      chk("clr_busy", busy, 1'b1);
      chk("clr_ready", req_ready, 3'b000);
      @(posedge clk); #1;
      chk("clr_we", rf_write_enable, 1'b1);
      chk("clr_addr", rf_address_W, 64'(k));
      chk("clr_data", rf_write_data, 32'd0);
      if (clear_done) done_cnt++;
    end
    #1;
    chk("clr_busy_end", busy, 1'b0);
    chk("clr_done_last", clear_done, 1'b1);
    chk("clr_ready_after", req_ready, 3'b100);
    @(posedge clk); #1; v = '0;
    if (clear_done) done_cnt++;
    chk("clr_done_count", 64'(done_cnt), 64'd1);
    chk("post_clr_addr", rf_address_W, 5'd3);
    chk("post_clr_data", rf_write_data, 32'hAA);
    chk("post_clr_we", rf_write_enable, 1'b1);

    // ---- reset in the middle of a clear
    clear_req = 1'b1; @(posedge clk); #1; clear_req = 1'b0;
    repeat (11) @(posedge clk);
    #3; rst_n = 1'b0; #1;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_done", clear_done, 1'b0);
    chk("mrst_we", rf_write_enable, 1'b0);
    @(posedge clk); #1; rst_n = 1'b1;
    done_cnt = 0;
    repeat (35) begin @(posedge clk); #1; if (clear_done || busy) done_cnt++; end
    chk("mrst_no_done", 64'(done_cnt), 64'd0);
    clear_req = 1'b1; @(posedge clk); #1; clear_req = 1'b0;
    @(posedge clk); #1;
    chk("mrst_restart_addr", rf_address_W, 5'd1);
    chk("mrst_restart_we", rf_write_enable, 1'b1);

    // ---- random traffic against the model
    rst_n = 1'b0; shadow_clr = 1'b1; v = '0;
    @(posedge clk); #1;
    shadow_clr = 1'b0; rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 32; i++) mrf[i] = 32'hA5A5_0000 | 32'(i);
    shadow_on = 1'b1;
    for (int c = 0; c < 1500; c++) rcycle(1'b1);
    for (int c = 0; c < 40; c++) rcycle(1'b0);
    for (int i = 0; i < 32; i++) chk($sformatf("rf_reg%0d", i), srf[i], mrf[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
